ahb_bus_arbiter: RTL and testbench

- Round-robin AHB arbiter and address/data-phase mux that shares the AHB-to-APB bridge slave port between up to 4 AHB masters.
- Sits between the masters and the bridge: grants the bus, steers the owner's address/control onto the bridge, and steers the data-phase owner's write data one transfer later.
- Never re-arbitrates inside a fixed-length burst.

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_bus_arbiter_if.sv | 44 ++++
 rtl/ahb_rr_picker.sv | 29 ++
 rtl/ahb_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB transfer/burst codes, bus widths and the
// fixed-burst length helper shared by the arbiter slice.
package ahb_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  // INCR has no fixed length; it reports 1 so that L-1 is 0
  function automatic logic [4:0] burst_len(input logic [2:0] hb);
    logic [4:0] l;
    unique case (hb)
      WRAP4, INCR4:   l = 5'd4;
      WRAP8, INCR8:   l = 5'd8;
      WRAP16, INCR16: l = 5'd16;
      default:        l = 5'd1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: per-master request/address/data bundle
// plus the muxed bridge-side bus of the shared AHB port.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  import ahb_pkg::*;

  logic [NUM_MASTERS-1:0]    m_hbusreq;
  logic [AW*NUM_MASTERS-1:0] m_haddr;
  logic [2*NUM_MASTERS-1:0]  m_htrans;
  logic [NUM_MASTERS-1:0]    m_hwrite;
  logic [3*NUM_MASTERS-1:0]  m_hsize;
  logic [3*NUM_MASTERS-1:0]  m_hburst;
  logic [DW*NUM_MASTERS-1:0] m_hwdata;
  logic                      hreadyout;

  logic [NUM_MASTERS-1:0]    hgrant;
  logic [1:0]                hmaster;
  logic [1:0]                hmaster_data;
  logic [AW-1:0]             haddr;
  logic [1:0]                htrans;
  logic                      hwrite;
  logic [2:0]                hsize;
  logic [2:0]                hburst;
  logic [DW-1:0]             hwdata;
  logic                      hreadyin;

  modport slave (
    input  m_hbusreq, m_haddr, m_htrans, m_hwrite,
    input  m_hsize, m_hburst, m_hwdata, hreadyout,
    output hgrant, hmaster, hmaster_data,
    output haddr, htrans, hwrite, hsize, hburst,
    output hwdata, hreadyin
  );

  modport master (
    output m_hbusreq, m_haddr, m_htrans, m_hwrite,
    output m_hsize, m_hburst, m_hwdata, hreadyout,
    input  hgrant, hmaster, hmaster_data,
    input  haddr, htrans, hwrite, hsize, hburst,
    input  hwdata, hreadyin
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker: combinational round-robin search starting
// one past last_i, wrapping; returns one-hot winner and index.
module ahb_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   last_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         valid_o
);

  always_comb begin
    int j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = last_i;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = 2'(j);
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst lock and
// address/data-phase steering onto the shared bridge port.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input logic hclk,
  input logic hresetn,
  ahb_bus_arbiter_if.slave bus
);

  localparam int N = NUM_MASTERS;
  localparam logic [1:0] DEF = 2'(DEFAULT_MASTER);
  localparam logic [N-1:0] DEF_OH =
    {{(N-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [N-1:0]  hgrant_q, hgrant_d;
  logic [1:0]    hmaster_q, hmaster_d;
  logic [1:0]    hmaster_data_q, hmaster_data_d;
  logic [4:0]    beat_cnt_q, beat_cnt_d, beat_nxt;
  logic [1:0]    last_grant_q, last_grant_d;

  logic [AW-1:0] own_addr;
  logic [1:0]    own_trans;
  logic          own_write;
  logic [2:0]    own_size;
  logic [2:0]    own_burst;
  logic          own_req;
  logic [DW-1:0] dat_wdata;
  logic [1:0]    gidx;
  logic          lock;

  logic [N-1:0]  pick_gnt;
  logic [1:0]    pick_idx;
  logic          pick_vld;

  ahb_rr_picker #(.N(N)) u_pick (
    .req_i   (bus.m_hbusreq),
    .last_i  (last_grant_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    own_addr  = '0;
    own_trans = '0;
    own_write = 1'b0;
    own_size  = '0;
    own_burst = '0;
    own_req   = 1'b0;
    dat_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (hmaster_q == 2'(i)) begin
        own_addr  = bus.m_haddr[AW*i +: AW];
        own_trans = bus.m_htrans[2*i +: 2];
        own_write = bus.m_hwrite[i];
        own_size  = bus.m_hsize[3*i +: 3];
        own_burst = bus.m_hburst[3*i +: 3];
        own_req   = bus.m_hbusreq[i];
      end
      if (hmaster_data_q == 2'(i))
        dat_wdata = bus.m_hwdata[DW*i +: DW];
    end
  end

  assign bus.haddr        = own_addr;
  assign bus.htrans       = own_trans;
  assign bus.hwrite       = own_write;
  assign bus.hsize        = own_size;
  assign bus.hburst       = own_burst;
  assign bus.hwdata       = dat_wdata;
  assign bus.hreadyin     = bus.hreadyout;
  assign bus.hgrant       = hgrant_q;
  assign bus.hmaster      = hmaster_q;
  assign bus.hmaster_data = hmaster_data_q;

  always_comb begin
    gidx = DEF;
    for (int i = 0; i < N; i++)
      if (hgrant_q[i]) gidx = 2'(i);
  end

  always_comb begin
    beat_nxt = beat_cnt_q;
    unique case (own_trans)
      NONSEQ:  beat_nxt = burst_len(own_burst) - 5'd1;
      SEQ:     beat_nxt = (beat_cnt_q == 5'd0) ? 5'd0
                        : beat_cnt_q - 5'd1;
      IDLE:    beat_nxt = 5'd0;
      default: beat_nxt = beat_cnt_q;
    endcase
  end

  // fixed bursts release one beat early so the next owner's
  // address phase follows the final beat with no gap
  assign lock = (beat_nxt > 5'd1)
             || (own_req && own_burst == INCR
                 && own_trans != IDLE);

  always_comb begin
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    hmaster_data_d = hmaster_data_q;
    beat_cnt_d     = beat_cnt_q;
    last_grant_d   = last_grant_q;
    if (bus.hreadyout) begin
      hmaster_d      = gidx;
      hmaster_data_d = hmaster_q;
      beat_cnt_d     = beat_nxt;
      if (!lock) begin
        if (pick_vld) begin
          hgrant_d     = pick_gnt;
          last_grant_d = pick_idx;
        end else begin
          hgrant_d = DEF_OH;
        end
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant_q       <= DEF_OH;
      hmaster_q      <= DEF;
      hmaster_data_q <= DEF;
      beat_cnt_q     <= '0;
      last_grant_q   <= DEF;
    end else begin
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      beat_cnt_q     <= beat_cnt_d;
      last_grant_q   <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed steps with a cycle-stamped
// expectation queue checked at each falling edge.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int NM = 2;
  localparam int S_GNT  = 0;
  localparam int S_MST  = 1;
  localparam int S_MSTD = 2;
  localparam int S_ADDR = 3;
  localparam int S_TRN  = 4;
  localparam int S_WD   = 5;
  localparam int S_RDY  = 6;
  localparam int S_BEAT = 7;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
  );

  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_GNT:  return 32'(bus.hgrant);
      S_MST:  return 32'(bus.hmaster);
      S_MSTD: return 32'(bus.hmaster_data);
      S_ADDR: return bus.haddr;
      S_TRN:  return 32'(bus.htrans);
      S_WD:   return bus.hwdata;
      S_RDY:  return 32'(bus.hreadyin);
      S_BEAT: return 32'(dut.beat_cnt_q);
      default: return 32'hx;
    endcase
  endfunction

  task automatic ex(input int at, input int sig,
                    input logic [31:0] val, input string tag);
    exp_t e;
    e.at = at; e.sig = sig; e.val = val; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic chk();
    exp_t keep[$];
    logic [31:0] o;
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].at == cyc) begin
        o = obs(sbq[i].sig);
        n_cmp++;
        assert (o === sbq[i].val) else begin
          n_bad++;
          $error("FAIL %s cyc%0d: got %h want %h",
                 sbq[i].tag, cyc, o, sbq[i].val);
        end
      end else begin
        keep.push_back(sbq[i]);
      end
    end
    sbq = keep;
  endtask

  task automatic probe();
    @(negedge hclk);
    chk();
  endtask

  task automatic adv();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  task automatic step();
    probe();
    adv();
  endtask

  task automatic mset(input int m, input logic [31:0] a,
                      input logic [1:0] t, input logic [2:0] hb,
                      input logic w);
    bus.m_haddr[32*m +: 32] = a;
    bus.m_htrans[2*m +: 2]  = t;
    bus.m_hburst[3*m +: 3]  = hb;
    bus.m_hsize[3*m +: 3]   = 3'd2;
    bus.m_hwrite[m]         = w;
  endtask

  task automatic mwd(input int m, input logic [31:0] d);
    bus.m_hwdata[32*m +: 32] = d;
  endtask

  initial begin
    hresetn       = 1'b0;
    bus.hreadyout = 1'b1;
    bus.m_hbusreq = '0;
    bus.m_haddr   = '0;
    bus.m_htrans  = '0;
    bus.m_hwrite  = '0;
    bus.m_hsize   = '0;
    bus.m_hburst  = '0;
    bus.m_hwdata  = '0;
    mwd(0, 32'h0BAD_0000);
    mwd(1, 32'h1111_1111);

    // reset state, then idle after release
    ex(0, S_GNT, 1, "rst_gnt");
    ex(0, S_MST, 0, "rst_mst");
    ex(0, S_MSTD, 0, "rst_mstd");
    ex(0, S_TRN, 0, "rst_trn");
    ex(0, S_WD, 32'h0BAD_0000, "rst_wd");
    ex(0, S_BEAT, 0, "rst_beat");
    step();
    hresetn = 1'b1;
    ex(2, S_GNT, 1, "idle_gnt");
    ex(2, S_MST, 0, "idle_mst");
    ex(2, S_TRN, 0, "idle_trn");
    ex(2, S_RDY, 1, "idle_rdy");
    step(); step();

    // M1 single write
    bus.m_hbusreq = 2'b10;
    ex(4, S_GNT, 2, "s1_gnt");
    step(); step();
    bus.m_hbusreq = 2'b00;
    mset(1, 32'h8000_0001, NONSEQ, SINGLE, 1'b1);
    ex(5, S_MST, 1, "s1_mst");
    ex(5, S_ADDR, 32'h8000_0001, "s1_addr");
    ex(5, S_TRN, 2, "s1_trn");
    ex(6, S_GNT, 1, "s1_gnt_back");
    ex(6, S_MSTD, 1, "s1_mstd");
    ex(6, S_WD, 32'h80, "s1_wd");
    step();
    mset(1, 32'h0, IDLE, SINGLE, 1'b0);
    mwd(1, 32'h80);
    ex(7, S_MST, 0, "s1_mst0");
    ex(7, S_MSTD, 1, "s1_mstd1");
    ex(8, S_MSTD, 0, "s1_mstd0");
    step(); step(); step();

    // M0 alone sets last_grant=0, then both alternate
    bus.m_hbusreq = 2'b01;
    step();
    bus.m_hbusreq = 2'b11;
    mset(0, 32'h1000, NONSEQ, SINGLE, 1'b0);
    mset(1, 32'h2000, NONSEQ, SINGLE, 1'b0);
    ex(11, S_GNT, 2, "rr_g11");
    ex(12, S_GNT, 1, "rr_g12");
    ex(12, S_MST, 1, "rr_m12");
    ex(12, S_ADDR, 32'h2000, "rr_a12");
    ex(13, S_GNT, 2, "rr_g13");
    ex(13, S_MST, 0, "rr_m13");
    ex(13, S_ADDR, 32'h1000, "rr_a13");
    ex(14, S_GNT, 1, "rr_g14");
    step(); step(); step(); step();
    bus.m_hbusreq = 2'b00;
    mset(0, 32'h0, IDLE, SINGLE, 1'b0);
    mset(1, 32'h0, IDLE, SINGLE, 1'b0);
    step(); step();

    // M0 INCR4 while M1 requests; M0 drops req mid-burst
    bus.m_hbusreq = 2'b11;
    mset(0, 32'h8000_0001, NONSEQ, INCR4, 1'b1);
    ex(16, S_GNT, 1, "b4_g1");
    ex(16, S_MST, 0, "b4_m1");
    step();
    bus.m_hbusreq = 2'b10;
    mset(0, 32'h8000_0002, SEQ, INCR4, 1'b1);
    mwd(0, 32'hD1);
    ex(17, S_GNT, 1, "b4_g2");
    ex(17, S_BEAT, 3, "b4_c2");
    ex(17, S_ADDR, 32'h8000_0002, "b4_a2");
    step();
    mset(0, 32'h8000_0003, SEQ, INCR4, 1'b1);
    mwd(0, 32'hD2);
    ex(18, S_GNT, 1, "b4_g3");
    ex(18, S_BEAT, 2, "b4_c3");
    ex(18, S_WD, 32'hD2, "b4_wd2");
    step();
    mset(0, 32'h8000_0004, SEQ, INCR4, 1'b1);
    mwd(0, 32'hD3);
    ex(19, S_GNT, 2, "b4_g4");
    ex(19, S_MST, 0, "b4_m4");
    ex(19, S_ADDR, 32'h8000_0004, "b4_a4");
    ex(19, S_BEAT, 1, "b4_c4");
    step();
    bus.m_hbusreq = 2'b00;
    mset(0, 32'h0, IDLE, SINGLE, 1'b0);
    mset(1, 32'h9000_0000, NONSEQ, SINGLE, 1'b0);
    mwd(0, 32'hD4);
    ex(20, S_MST, 1, "b4_m1own");
    ex(20, S_ADDR, 32'h9000_0000, "b4_a1own");
    ex(20, S_MSTD, 0, "b4_md");
    ex(20, S_WD, 32'hD4, "b4_wd4");
    step();
    mset(1, 32'h0, IDLE, SINGLE, 1'b0);
    ex(21, S_GNT, 1, "b4_gdef");
    ex(21, S_MSTD, 1, "b4_md1");
    step(); step();

    // wait states mid-INCR4 freeze everything
    bus.m_hbusreq = 2'b11;
    mset(0, 32'h100, NONSEQ, INCR4, 1'b0);
    ex(23, S_MST, 0, "ws_m0");
    step();
    bus.m_hbusreq = 2'b10;
    mset(0, 32'h104, SEQ, INCR4, 1'b0);
    ex(24, S_BEAT, 3, "ws_c24");
    ex(24, S_GNT, 1, "ws_g24");
    step();
    mset(0, 32'h108, SEQ, INCR4, 1'b0);
    bus.hreadyout = 1'b0;
    for (int c = 25; c <= 28; c++) begin
      ex(c, S_BEAT, 2, "ws_cnt");
      ex(c, S_GNT, 1, "ws_gnt");
      ex(c, S_MST, 0, "ws_mst");
      ex(c, S_MSTD, 0, "ws_mstd");
      ex(c, S_ADDR, 32'h108, "ws_addr");
    end
    ex(26, S_RDY, 0, "ws_rdy0");
    ex(28, S_RDY, 1, "ws_rdy1");
    step(); step(); step();
    bus.hreadyout = 1'b1;
    step();
    mset(0, 32'h10C, SEQ, INCR4, 1'b0);
    ex(29, S_GNT, 2, "ws_g29");
    ex(29, S_BEAT, 1, "ws_c29");
    ex(29, S_ADDR, 32'h10C, "ws_a29");
    step();
    bus.m_hbusreq = 2'b00;
    mset(0, 32'h0, IDLE, SINGLE, 1'b0);
    ex(30, S_MST, 1, "ws_m30");
    ex(30, S_BEAT, 0, "ws_c30");
    step(); step();

    // reset during beat 2 of an M1 INCR4
    bus.m_hbusreq = 2'b10;
    mwd(0, 32'h0BAD_0000);
    step(); step();
    mset(1, 32'h200, NONSEQ, INCR4, 1'b1);
    ex(34, S_MST, 1, "rb_m34");
    ex(34, S_GNT, 2, "rb_g34");
    step();
    mset(1, 32'h204, SEQ, INCR4, 1'b1);
    mwd(1, 32'hA1);
    ex(35, S_BEAT, 3, "rb_c35");
    ex(35, S_GNT, 2, "rb_g35");
    ex(35, S_MSTD, 1, "rb_md35");
    ex(35, S_WD, 32'hA1, "rb_wd35");
    ex(35, S_ADDR, 32'h204, "rb_a35");
    probe();
    #2;
    hresetn = 1'b0;
    #1;
    ex(35, S_GNT, 1, "rb_rgnt");
    ex(35, S_MST, 0, "rb_rmst");
    ex(35, S_MSTD, 0, "rb_rmstd");
    ex(35, S_BEAT, 0, "rb_rbeat");
    ex(35, S_WD, 32'h0BAD_0000, "rb_rwd");
    ex(35, S_TRN, 0, "rb_rtrn");
    chk();
    adv();
    bus.m_hbusreq = 2'b00;
    mset(1, 32'h0, IDLE, SINGLE, 1'b0);
    hresetn = 1'b1;
    ex(37, S_GNT, 1, "rb_post_g");
    ex(37, S_MST, 0, "rb_post_m");
    ex(37, S_BEAT, 0, "rb_post_c");
    step(); step(); step();

    for (int i = 0; i < sbq.size(); i++) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: expectation for cyc%0d never checked",
             sbq[i].tag, sbq[i].at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
